// File: rtl/uno_player_hand.sv
// UNO player hand: draws cards from the deck into a compacted array and plays a
// selected card back to the deck after a legality check against the discard top.
module uno_player_hand #(
   parameter int MAX_CARDS = 32,
   parameter int DEAL_N    = 7,
   localparam int IW       = $clog2(MAX_CARDS)
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_deal,
   input  logic [2:0]    i_draw_req,
   output logic [2:0]    o_draw,
   input  logic          i_deck_done,
   input  logic          i_drawn,
   input  logic [5:0]    i_card,
   input  logic          i_play,
   input  logic [IW-1:0] i_sel,
   input  logic [5:0]    i_top_card,
   output logic          o_insert,
   output logic [5:0]    o_prev_card,
   output logic          o_illegal,
   output logic [5:0]    o_card_sel,
   output logic [IW:0]   o_count,
   output logic          o_empty,
   output logic          o_full,
   output logic          o_busy
);

   localparam int PW = (DEAL_N > 4) ? $clog2(DEAL_N + 1) : 3;
   localparam logic [IW:0] MAXC = (IW+1)'(MAX_CARDS);

   typedef enum logic [1:0] {IDLE, REQ, WAIT_DONE, SHIFT} state_t;

   state_t        state_q;
   logic [5:0]    hand_q [MAX_CARDS];
   logic [IW:0]   count_q;
   logic [PW-1:0] pend_q;
   logic [IW-1:0] ptr_q;
   logic          insert_q;
   logic          illegal_q;
   logic [5:0]    prev_q;

   logic [IW:0]   sel_x;
   logic [IW:0]   cnt_m1;
   logic [IW:0]   cnt_m2;
   logic          sel_ok;
   logic          full;
   logic [5:0]    sel_card;
   logic [PW-1:0] req_n;

   // Same color, same value, or any wild (value 13 and above) may be played.
   function automatic logic play_ok(input logic [5:0] c, input logic [5:0] t);
      return (c[5:4] == t[5:4]) || (c[3:0] == t[3:0]) || (c[3:0] >= 4'd13);
   endfunction

   assign sel_x      = {1'b0, i_sel};
   assign cnt_m1     = count_q - 1'b1;
   assign cnt_m2     = count_q - 2'd2;
   assign sel_ok     = sel_x < count_q;
   assign sel_card   = hand_q[i_sel];
   assign full       = (count_q == MAXC);
   assign o_card_sel = sel_ok ? sel_card : 6'd0;

   always_comb begin
      req_n = '0;
      case (i_draw_req)
         3'b001:  req_n = PW'(1);
         3'b010:  req_n = PW'(2);
         3'b100:  req_n = PW'(4);
         default: req_n = '0;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= IDLE;
         count_q   <= '0;
         pend_q    <= '0;
         ptr_q     <= '0;
         insert_q  <= 1'b0;
         illegal_q <= 1'b0;
         prev_q    <= '0;
         for (int i = 0; i < MAX_CARDS; i++) hand_q[i] <= '0;
      end else begin
         insert_q  <= 1'b0;
         illegal_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (i_deal) begin
                  pend_q  <= PW'(DEAL_N);
                  state_q <= REQ;
               end else if (req_n != '0) begin
                  pend_q  <= req_n;
                  state_q <= REQ;
               end else if (i_play) begin
                  if (sel_ok && play_ok(sel_card, i_top_card)) begin
                     insert_q <= 1'b1;
                     prev_q   <= sel_card;
                     if (sel_x == cnt_m1) begin
                        hand_q[i_sel] <= '0;
                        count_q       <= cnt_m1;
                     end else begin
                        ptr_q   <= i_sel;
                        state_q <= SHIFT;
                     end
                  end else begin
                     illegal_q <= 1'b1;
                  end
               end
            end
            REQ: begin
               if (i_drawn) begin
                  // A card arriving with the hand already full is dropped.
                  if (!full) begin
                     hand_q[count_q[IW-1:0]] <= i_card;
                     count_q                 <= count_q + 1'b1;
                  end
                  pend_q  <= pend_q - 1'b1;
                  state_q <= WAIT_DONE;
               end
            end
            WAIT_DONE: begin
               if (i_deck_done) begin
                  if ((pend_q != '0) && !full) begin
                     state_q <= REQ;
                  end else begin
                     pend_q  <= '0;
                     state_q <= IDLE;
                  end
               end
            end
            SHIFT: begin
               hand_q[ptr_q] <= hand_q[ptr_q + 1'b1];
               if ({1'b0, ptr_q} == cnt_m2) begin
                  hand_q[cnt_m1[IW-1:0]] <= '0;
                  count_q                <= cnt_m1;
                  state_q                <= IDLE;
               end else begin
                  ptr_q <= ptr_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign o_draw      = (state_q == REQ) ? 3'b001 : 3'b000;
   assign o_insert    = insert_q;
   assign o_prev_card = prev_q;
   assign o_illegal   = illegal_q;
   assign o_count     = count_q;
   assign o_empty     = (count_q == '0);
   assign o_full      = full;
   assign o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uno_player_hand.sv
// Bench for uno_player_hand: directed scenarios plus random play/draw traffic,
// checked against a queue-based model of the hand.
module tb_uno_player_hand;

   localparam int MAX = 32;

   logic       clk = 1'b0;
   logic       i_rst = 1'b0;
   logic       i_deal = 1'b0;
   logic [2:0] i_draw_req = 3'b000;
   logic [2:0] o_draw;
   logic       i_deck_done = 1'b1;
   logic       i_drawn = 1'b0;
   logic [5:0] i_card = 6'd0;
   logic       i_play = 1'b0;
   logic [4:0] i_sel = 5'd0;
   logic [5:0] i_top_card = 6'd0;
   logic       o_insert;
   logic [5:0] o_prev_card;
   logic       o_illegal;
   logic [5:0] o_card_sel;
   logic [5:0] o_count;
   logic       o_empty;
   logic       o_full;
   logic       o_busy;

   int checks = 0;
   int passes = 0;

   logic [5:0] m_hand[$];
   logic [5:0] feed[$];

   uno_player_hand dut (
      .i_clk       (clk),
      .i_rst       (i_rst),
      .i_deal      (i_deal),
      .i_draw_req  (i_draw_req),
      .o_draw      (o_draw),
      .i_deck_done (i_deck_done),
      .i_drawn     (i_drawn),
      .i_card      (i_card),
      .i_play      (i_play),
      .i_sel       (i_sel),
      .i_top_card  (i_top_card),
      .o_insert    (o_insert),
      .o_prev_card (o_prev_card),
      .o_illegal   (o_illegal),
      .o_card_sel  (o_card_sel),
      .o_count     (o_count),
      .o_empty     (o_empty),
      .o_full      (o_full),
      .o_busy      (o_busy)
   );

   always #5 clk = ~clk;

   initial begin
      #900000;
      $display("FAIL watchdog: observed no finish, expected finish before 900000");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [5:0] rand_card();
      return {2'($urandom_range(0, 3)), 4'($urandom_range(0, 14))};
   endfunction

   function automatic bit legal_play(input int sel, input logic [5:0] top);
      logic [5:0] c;
      if (sel >= m_hand.size()) return 1'b0;
      c = m_hand[sel];
      return (c[5:4] == top[5:4]) || (c[3:0] == top[3:0]) || (c[3:0] >= 4'd13);
   endfunction

   task automatic reset_dut();
      @(negedge clk);
      i_rst = 1'b1; i_deal = 1'b0; i_draw_req = 3'b000; i_play = 1'b0;
      i_drawn = 1'b0; i_deck_done = 1'b1;
      @(posedge clk);
      #1 i_rst = 1'b0;
      m_hand.delete();
      feed.delete();
   endtask

   task automatic check_hand(input string tag);
      logic [5:0] exp;
      for (int i = 0; i < MAX; i++) begin
         @(negedge clk);
         i_sel = 5'(i);
         #1;
         exp = (i < m_hand.size()) ? m_hand[i] : 6'd0;
         chk({tag, "_slot"}, 32'(o_card_sel), 32'(exp));
      end
      chk({tag, "_count"}, 32'(o_count), m_hand.size());
      chk({tag, "_empty"}, 32'(o_empty), 32'(m_hand.size() == 0));
      chk({tag, "_full"}, 32'(o_full), 32'(m_hand.size() == MAX));
      chk({tag, "_busy"}, 32'(o_busy), 0);
   endtask

   // Launch a deal or a one-hot draw, act as the deck until the hand goes idle.
   task automatic draw_op(input logic deal, input logic [2:0] req, input logic with_play);
      int room, pend, n_exp, n, cyc;
      bit done, saw_ins, saw_ill, bad_draw;
      logic [5:0] card;
      room  = MAX - m_hand.size();
      pend  = deal ? 7 : (req == 3'b001 ? 1 : (req == 3'b010 ? 2 : 4));
      n_exp = (room == 0) ? 1 : ((pend < room) ? pend : room);
      n = 0; cyc = 0; done = 0; saw_ins = 0; saw_ill = 0; bad_draw = 0;
      @(negedge clk);
      i_deal = deal; i_draw_req = req; i_play = with_play;
      i_sel = 5'd0;
      i_top_card = (m_hand.size() > 0) ? m_hand[0] : 6'd0;
      @(posedge clk);
      #1 i_deal = 1'b0; i_draw_req = 3'b000; i_play = 1'b0;
      while (!done && cyc < 400) begin
         @(negedge clk);
         cyc++;
         saw_ins |= o_insert;
         saw_ill |= o_illegal;
         if (o_draw != 3'b000 && o_draw != 3'b001) bad_draw = 1;
         if (!o_busy) done = 1;
         else begin
            i_deck_done = ($urandom_range(0, 3) != 0);
            if (o_draw == 3'b001 && $urandom_range(0, 2) != 0) begin
               card = (feed.size() > 0) ? feed.pop_front() : rand_card();
               i_card = card; i_drawn = 1'b1;
               @(posedge clk);
               #1 i_drawn = 1'b0; i_card = rand_card();
               n++;
               if (m_hand.size() < MAX) m_hand.push_back(card);
            end
         end
      end
      i_deck_done = 1'b1;
      chk("draw_finished", 32'(done), 1);
      chk("draw_requests", n, n_exp);
      chk("draw_code", 32'(bad_draw), 0);
      chk("draw_no_insert", 32'(saw_ins), 0);
      chk("draw_no_illegal", 32'(saw_ill), 0);
      chk("draw_count", 32'(o_count), m_hand.size());
   endtask

   task automatic play(input int sel, input logic [5:0] top, input logic [2:0] req);
      int sz, exp_sh, nb;
      bit lg;
      logic [5:0] c;
      sz = m_hand.size();
      lg = legal_play(sel, top);
      c = (sel < sz) ? m_hand[sel] : 6'd0;
      exp_sh = (lg && sel != sz - 1) ? (sz - 1 - sel) : 0;
      @(negedge clk);
      i_sel = 5'(sel); i_top_card = top; i_draw_req = req; i_play = 1'b1;
      #1 chk("card_sel", 32'(o_card_sel), 32'(c));
      @(posedge clk);
      #1 i_play = 1'b0; i_draw_req = 3'b000;
      @(negedge clk);
      chk("insert", 32'(o_insert), 32'(lg));
      chk("illegal", 32'(o_illegal), 32'(!lg));
      if (lg) chk("prev_card", 32'(o_prev_card), 32'(c));
      nb = o_busy ? 1 : 0;
      @(negedge clk);
      chk("insert_1cyc", 32'(o_insert), 0);
      chk("illegal_1cyc", 32'(o_illegal), 0);
      while (o_busy && nb < 64) begin
         nb++;
         @(negedge clk);
      end
      chk("shift_cycles", nb, exp_sh);
      if (lg) m_hand.delete(sel);
      chk("play_count", 32'(o_count), m_hand.size());
   endtask

   initial begin
      int n, cyc, sel, op;
      logic [2:0] onehot [3];
      logic [2:0] noise [5];
      onehot = '{3'b001, 3'b010, 3'b100};
      noise  = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};

      // reset state
      reset_dut();
      @(negedge clk);
      chk("rst_count", 32'(o_count), 0);
      chk("rst_empty", 32'(o_empty), 1);
      chk("rst_full", 32'(o_full), 0);
      chk("rst_busy", 32'(o_busy), 0);
      chk("rst_draw", 32'(o_draw), 0);
      chk("rst_insert", 32'(o_insert), 0);
      chk("rst_illegal", 32'(o_illegal), 0);
      chk("rst_prev", 32'(o_prev_card), 0);

      // deal of seven: R1..R7
      for (int i = 1; i <= 7; i++) feed.push_back(6'(i));
      draw_op(1'b1, 3'b000, 1'b0);
      check_hand("deal");

      // hand {Y5,G9,B13}, top R5
      reset_dut();
      feed.push_back(6'h15); feed.push_back(6'h29); feed.push_back(6'h3D);
      draw_op(1'b0, 3'b010, 1'b0);
      draw_op(1'b0, 3'b001, 1'b0);
      check_hand("three");
      play(1, 6'h05, 3'b000);
      play(0, 6'h05, 3'b000);
      check_hand("after_y5");

      // wild at last index, top R3
      play(1, 6'h03, 3'b000);
      check_hand("after_wild");

      // fill to 30, then a draw of 4 must stop at full
      for (int i = 0; i < 4; i++) draw_op(1'b1, 3'b000, 1'b0);
      draw_op(1'b0, 3'b001, 1'b0);
      chk("count_30", 32'(o_count), 30);
      draw_op(1'b0, 3'b100, 1'b0);
      check_hand("full");
      draw_op(1'b0, 3'b001, 1'b0);
      check_hand("full_discard");

      // random traffic
      for (int it = 0; it < 40; it++) begin
         op = $urandom_range(0, 3);
         if (op == 0) begin
            play($urandom_range(0, MAX - 1), rand_card(), noise[$urandom_range(0, 4)]);
         end else if (op == 1 && m_hand.size() > 0) begin
            sel = $urandom_range(0, m_hand.size() - 1);
            play(sel, {m_hand[sel][5:4], 4'($urandom_range(0, 12))}, noise[$urandom_range(0, 4)]);
         end else if (op == 2) begin
            draw_op(1'b0, onehot[$urandom_range(0, 2)], 1'b0);
         end else if (m_hand.size() < 20) begin
            draw_op(1'b1, 3'b000, 1'b0);
         end
      end
      check_hand("random");

      // shrink, then draw with a simultaneous play that must be dropped
      while (m_hand.size() > 20) play($urandom_range(0, m_hand.size() - 1), 6'h0D, 3'b000);
      if (m_hand.size() == 0) draw_op(1'b0, 3'b001, 1'b0);
      draw_op(1'b0, 3'b010, 1'b1);
      check_hand("draw_with_play");
      play(m_hand.size(), 6'h0D, 3'b000);

      // reset in the middle of a deal with three draws pending
      reset_dut();
      @(negedge clk);
      i_deal = 1'b1;
      @(posedge clk);
      #1 i_deal = 1'b0;
      n = 0; cyc = 0;
      while (n < 4 && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (o_draw == 3'b001) begin
            i_card = rand_card(); i_drawn = 1'b1;
            @(posedge clk);
            #1 i_drawn = 1'b0;
            n++;
         end
      end
      chk("mid_draws", n, 4);
      cyc = 0;
      @(negedge clk);
      while (o_draw != 3'b001 && cyc < 50) begin
         cyc++;
         @(negedge clk);
      end
      chk("mid_req", 32'(o_draw), 32'(3'b001));
      chk("mid_count", 32'(o_count), 4);
      i_rst = 1'b1;
      @(posedge clk);
      #1 i_rst = 1'b0;
      @(negedge clk);
      chk("mrst_draw", 32'(o_draw), 0);
      chk("mrst_count", 32'(o_count), 0);
      chk("mrst_busy", 32'(o_busy), 0);
      i_card = 6'h11; i_drawn = 1'b1;
      @(posedge clk);
      #1 i_drawn = 1'b0;
      @(negedge clk);
      chk("late_drawn_count", 32'(o_count), 0);
      chk("late_drawn_busy", 32'(o_busy), 0);
      chk("late_drawn_draw", 32'(o_draw), 0);
      m_hand.delete();
      check_hand("post_reset");

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
